// File: rtl/kernel_scheduler_pkg.sv
// Shared types for the kernel scheduler: FSM states, completion status codes
// and the helper that ranks completion causes.
package kernel_scheduler_pkg;

  localparam int unsigned AddrWidth    = 17;
  // Cycles the control unit may stay idle after a launch before the kernel
  // is declared lost.
  localparam int unsigned StartTimeout = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitStart,
    StRun,
    StDrain,
    StReport,
    StAbort
  } sched_state_e;

  typedef enum logic [1:0] {
    StatusOk      = 2'd0,
    StatusCuError = 2'd1,
    StatusTimeout = 2'd2,
    StatusBadAddr = 2'd3
  } done_status_e;

  // Timeout outranks a bad address, which outranks a control-unit error.
  function automatic done_status_e pick_status(input logic timeout, input logic bad_addr,
                                               input logic cu_err);
    if (timeout) return StatusTimeout;
    if (bad_addr) return StatusBadAddr;
    if (cu_err) return StatusCuError;
    return StatusOk;
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Power-of-two FIFO for pending kernel launches. A push offered while full is
// dropped even if a pop happens in the same cycle.
module sched_fifo #(
  parameter int unsigned LogDepth = 2,
  parameter int unsigned Width    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Depth = 2 ** LogDepth;
  localparam logic [LogDepth-1:0] PtrOne = 1;
  localparam logic [LogDepth:0]   CntOne = 1;

  logic [Width-1:0]    mem_q [Depth];
  logic [LogDepth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LogDepth:0]   count_q, count_d;
  logic                do_push, do_pop;

  // Count never exceeds Depth, so its top bit alone flags full.
  assign full_o  = count_q[LogDepth];
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_pop) rd_ptr_d = rd_ptr_q + PtrOne;
    if (do_push && !do_pop) begin
      count_d = count_q + CntOne;
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntOne;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/kernel_scheduler.sv
// Kernel scheduler: queues host launches, hands each to the control unit,
// supervises start and run time, and reports one completion per kernel.
module kernel_scheduler
  import kernel_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_LOG_DEPTH = 2,
  parameter int unsigned TAG_BITS       = 4,
  parameter int unsigned WATCHDOG_BITS  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 launch_valid,
  output logic                 launch_ready,
  input  logic [AddrWidth-1:0] launch_address,
  input  logic [TAG_BITS-1:0]  launch_tag,
  output logic [AddrWidth-1:0] kernel_start_address,
  output logic                 cu_reset,
  input  logic                 cu_idle,
  input  logic                 cu_error,
  input  logic                 queues_empty,
  output logic                 done_valid,
  output logic [TAG_BITS-1:0]  done_tag,
  output logic [1:0]           done_status,
  output logic                 busy
);

  localparam logic [WATCHDOG_BITS-1:0] WdOne = 1;

  sched_state_e              state_q, state_d;
  logic [TAG_BITS-1:0]       tag_q, tag_d;
  logic                      err_q, err_d, tmo_q, tmo_d, bad_q, bad_d;
  logic [WATCHDOG_BITS-1:0]  wd_q, wd_d, wd_inc;
  logic [1:0]                ws_q, ws_d;
  logic [AddrWidth-1:0]      ksa_q, ksa_d;
  logic                      cu_reset_q, cu_reset_d, done_valid_q, done_valid_d;
  logic [TAG_BITS-1:0]       done_tag_q, done_tag_d;
  done_status_e              done_status_q, done_status_d;

  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [AddrWidth-1:0]      head_addr;
  logic [TAG_BITS-1:0]       head_tag;

  sched_fifo #(
    .LogDepth(FIFO_LOG_DEPTH),
    .Width   (AddrWidth + TAG_BITS)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (launch_valid),
    .pop_i  (fifo_pop),
    .wdata_i({launch_address, launch_tag}),
    .rdata_o({head_addr, head_tag}),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign launch_ready         = !fifo_full;
  assign busy                 = !((state_q == StIdle) && fifo_empty);
  assign wd_inc               = wd_q + WdOne;
  assign kernel_start_address = ksa_q;
  assign cu_reset             = cu_reset_q;
  assign done_valid           = done_valid_q;
  assign done_tag             = done_tag_q;
  assign done_status          = done_status_q;

  // Next-state and registered-output decode for the kernel lifecycle.
  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    err_d         = err_q;
    tmo_d         = tmo_q;
    bad_d         = bad_q;
    wd_d          = wd_q;
    ws_d          = ws_q;
    ksa_d         = '0;
    cu_reset_d    = 1'b0;
    done_valid_d  = 1'b0;
    done_tag_d    = done_tag_q;
    done_status_d = done_status_q;
    fifo_pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && cu_idle) begin
          fifo_pop = 1'b1;
          tag_d    = head_tag;
          err_d    = 1'b0;
          tmo_d    = 1'b0;
          bad_d    = (head_addr == '0);
          if (head_addr != '0) begin
            ksa_d   = head_addr;
            state_d = StLaunch;
          end else begin
            state_d = StReport;
          end
        end
      end
      StLaunch: begin
        ws_d    = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        err_d = err_q | cu_error;
        if (!cu_idle) begin
          wd_d    = '0;
          state_d = StRun;
        end else if (ws_q == 2'(StartTimeout - 1)) begin
          tmo_d   = 1'b1;
          state_d = StAbort;
        end else begin
          ws_d = ws_q + 2'd1;
        end
      end
      StRun: begin
        err_d = err_q | cu_error;
        wd_d  = wd_inc;
        if (cu_idle) begin
          state_d = StDrain;
        end else if (wd_inc == '1) begin
          tmo_d   = 1'b1;
          state_d = StAbort;
        end
      end
      StDrain: begin
        err_d = err_q | cu_error;
        wd_d  = wd_inc;
        if (queues_empty) begin
          state_d = StReport;
        end else if (wd_inc == '1) begin
          tmo_d   = 1'b1;
          state_d = StAbort;
        end
      end
      StAbort: begin
        cu_reset_d = 1'b1;
        state_d    = StReport;
      end
      StReport: begin
        done_valid_d  = 1'b1;
        done_tag_d    = tag_q;
        done_status_d = pick_status(tmo_q, bad_q, err_q);
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, per-kernel flags, timers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tag_q         <= '0;
      err_q         <= 1'b0;
      tmo_q         <= 1'b0;
      bad_q         <= 1'b0;
      wd_q          <= '0;
      ws_q          <= '0;
      ksa_q         <= '0;
      cu_reset_q    <= 1'b0;
      done_valid_q  <= 1'b0;
      done_tag_q    <= '0;
      done_status_q <= StatusOk;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      err_q         <= err_d;
      tmo_q         <= tmo_d;
      bad_q         <= bad_d;
      wd_q          <= wd_d;
      ws_q          <= ws_d;
      ksa_q         <= ksa_d;
      cu_reset_q    <= cu_reset_d;
      done_valid_q  <= done_valid_d;
      done_tag_q    <= done_tag_d;
      done_status_q <= done_status_d;
    end
  end

endmodule

// File: tb/tb_kernel_scheduler.sv
// Bench for kernel_scheduler: directed vector table, FIFO back-pressure and
// reset-abort sequences, then randomized kernels against a timing model.
module tb_kernel_scheduler;

  localparam int WdMax = 15;  // all-ones of the 4-bit watchdog used here

  logic        clk = 1'b0;
  logic        reset;
  logic        launch_valid, launch_ready;
  logic [16:0] launch_address, kernel_start_address;
  logic [3:0]  launch_tag, done_tag;
  logic        cu_reset, cu_idle, cu_error, queues_empty;
  logic        done_valid, busy;
  logic [1:0]  done_status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kernel_scheduler #(
    .FIFO_LOG_DEPTH(2),
    .TAG_BITS      (4),
    .WATCHDOG_BITS (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .launch_valid        (launch_valid),
    .launch_ready        (launch_ready),
    .launch_address      (launch_address),
    .launch_tag          (launch_tag),
    .kernel_start_address(kernel_start_address),
    .cu_reset            (cu_reset),
    .cu_idle             (cu_idle),
    .cu_error            (cu_error),
    .queues_empty        (queues_empty),
    .done_valid          (done_valid),
    .done_tag            (done_tag),
    .done_status         (done_status),
    .busy                (busy)
  );

  typedef struct {
    logic [16:0] addr;
    logic [3:0]  tag;
    int          d;       // idle cycles the CU shows in WAIT_START
    int          r;       // busy cycles the CU shows in RUN
    int          q;       // non-empty queue cycles in DRAIN
    bit          err;     // pulse cu_error in the first RUN cycle
    logic [1:0]  st;      // expected done_status
    int          rst_t;   // expected cu_reset cycle after launch, -1 none
    int          done_t;  // expected done_valid cycle after launch
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion predicted from the scheduler rules: a zero address reports at
  // once; four idle start cycles time out; fifteen watchdog ticks over RUN and
  // DRAIN time out; otherwise the kernel finishes after its phases.
  function automatic void model(input logic [16:0] addr, input int d, input int r, input int q,
                                input bit err, output logic [1:0] st, output int rst_t,
                                output int done_t);
    if (addr == 17'd0) begin
      st = 2'd3; rst_t = -1; done_t = 1;
    end else if (d >= 4) begin
      st = 2'd2; rst_t = 6; done_t = 7;
    end else if (r >= WdMax || (r + 1 + q) >= WdMax) begin
      st = 2'd2; rst_t = d + 3 + WdMax; done_t = d + 4 + WdMax;
    end else begin
      st = err ? 2'd1 : 2'd0; rst_t = -1; done_t = d + r + q + 5;
    end
  endfunction

  task automatic push(input logic [16:0] a, input logic [3:0] tg);
    @(negedge clk);
    launch_valid = 1'b1; launch_address = a; launch_tag = tg;
    @(negedge clk);
    launch_valid = 1'b0;
  endtask

  // Plays the control unit for one kernel and checks its whole lifecycle.
  task automatic serve(input logic [16:0] addr, input logic [3:0] tag, input int d, input int r,
                       input int q, input bit err, input logic [1:0] exp_st, input int exp_rst,
                       input int exp_done, input bit chk_lat);
    int waits, rst_t, rst_n, done_t, extra, ksa0, busy0, dtag, dst;
    waits = 0;
    if (addr != 17'd0) begin
      while (kernel_start_address == 17'd0 && waits < 10) begin
        @(negedge clk); waits++;
      end
    end else begin
      @(negedge clk); waits = 1;
    end
    if (chk_lat) check("launch_latency", waits, 1);
    ksa0 = int'(kernel_start_address); busy0 = int'(busy);
    rst_t = -1; rst_n = 0; done_t = -1; extra = 0; dtag = 0; dst = 0;
    for (int t = 0; t <= 60; t++) begin
      if (t > 0) begin
        @(negedge clk);
        launch_valid = 1'b0;
        if (kernel_start_address != 17'd0) extra++;
        if (cu_reset) begin
          rst_n++;
          if (rst_t < 0) rst_t = t;
        end
        if (done_valid) begin
          done_t = t; dtag = int'(done_tag); dst = int'(done_status);
        end
      end
      cu_idle      = !(addr != 17'd0 && d < 4 && t >= d + 1 && t <= d + 1 + r);
      queues_empty = (addr == 17'd0) || (t >= d + 3 + r + q);
      cu_error     = err && (addr != 17'd0) && (t == d + 2);
      if (done_t >= 0) break;
    end
    cu_idle = 1'b1; queues_empty = 1'b1; cu_error = 1'b0;
    check("start_address", ksa0, int'(addr));
    check("start_address_extra_cycles", extra, 0);
    check("busy_at_launch", busy0, 1);
    check("cu_reset_cycle", rst_t, exp_rst);
    check("cu_reset_pulses", rst_n, (exp_rst >= 0) ? 1 : 0);
    check("done_cycle", done_t, exp_done);
    check("done_tag", dtag, int'(tag));
    check("done_status", dst, int'(exp_st));
    @(negedge clk);
    check("done_valid_single", int'(done_valid), 0);
    check("done_tag_hold", int'(done_tag), int'(tag));
    check("done_status_hold", int'(done_status), int'(exp_st));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]  exp_q [$];
    logic [16:0] ra;
    logic [3:0]  rt;
    logic [1:0]  est;
    int          cnt, rd, rr, rq, ert, edn;
    bit          re, ready_exp;

    vecs[0] = '{17'h00040, 4'd3,  1, 10, 0,  1'b0, 2'd0, -1, 16};
    vecs[1] = '{17'h00000, 4'd7,  0, 0,  0,  1'b0, 2'd3, -1, 1};
    vecs[2] = '{17'h01234, 4'd5,  0, 3,  2,  1'b1, 2'd1, -1, 10};
    vecs[3] = '{17'h01235, 4'd6,  0, 3,  2,  1'b0, 2'd0, -1, 10};
    vecs[4] = '{17'h000ff, 4'd9,  4, 0,  0,  1'b0, 2'd2, 6,  7};
    vecs[5] = '{17'h10000, 4'd10, 2, 30, 0,  1'b0, 2'd2, 20, 21};
    vecs[6] = '{17'h1ffff, 4'd12, 0, 5,  12, 1'b0, 2'd2, 18, 19};
    vecs[7] = '{17'h00abc, 4'd13, 1, 30, 0,  1'b1, 2'd2, 19, 20};
    vecs[8] = '{17'h00777, 4'd14, 3, 2,  1,  1'b0, 2'd0, -1, 11};

    reset = 1'b1; launch_valid = 1'b0; launch_address = '0; launch_tag = '0;
    cu_idle = 1'b1; cu_error = 1'b0; queues_empty = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_launch_ready", int'(launch_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_start_address", int'(kernel_start_address), 0);
    check("reset_done_valid", int'(done_valid), 0);
    check("reset_cu_reset", int'(cu_reset), 0);
    check("reset_done_tag", int'(done_tag), 0);
    check("reset_done_status", int'(done_status), 0);

    for (int i = 0; i < 9; i++) begin
      push(vecs[i].addr, vecs[i].tag);
      serve(vecs[i].addr, vecs[i].tag, vecs[i].d, vecs[i].r, vecs[i].q, vecs[i].err,
            vecs[i].st, vecs[i].rst_t, vecs[i].done_t, 1'b1);
    end

    // Back-pressure: five offers into a four-entry FIFO with the CU busy.
    cnt = 0;
    cu_idle = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      ready_exp = (cnt < 4);
      check("fifo_ready_on_offer", int'(launch_ready), int'(ready_exp));
      launch_valid = 1'b1; launch_address = 17'h00100 + 17'(i); launch_tag = 4'(i);
      if (ready_exp && launch_ready) begin
        cnt++; exp_q.push_back(4'(i));
      end
    end
    @(negedge clk);
    check("fifo_full_ready_low", int'(launch_ready), 0);
    check("fifo_full_busy", int'(busy), 1);
    cu_idle = 1'b1;
    @(negedge clk);
    check("fifo_ready_after_pop", int'(launch_ready), 1);
    exp_q.push_back(4'd5);
    while (exp_q.size() > 0) begin
      rt = exp_q.pop_front();
      model(17'h00100 + 17'(rt), 0, 2, 0, 1'b0, est, ert, edn);
      serve(17'h00100 + 17'(rt), rt, 0, 2, 0, 1'b0, est, ert, edn, 1'b0);
    end

    // Reset while draining discards the kernel silently.
    push(17'h00200, 4'd2);
    @(negedge clk);
    check("abort_launch", int'(kernel_start_address), 32'h200);
    cu_idle = 1'b0; queues_empty = 1'b0;
    @(negedge clk);
    @(negedge clk); cu_idle = 1'b1;
    @(negedge clk);
    check("drain_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset_done_valid", int'(done_valid), 0);
    check("post_reset_ready", int'(launch_ready), 1);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_cu_reset", int'(cu_reset), 0);
    queues_empty = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_valid || cu_reset) cnt++;
    end
    check("post_reset_quiet", cnt, 0);

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(4, 0) == 0) ? 17'd0 : 17'($urandom_range(32'h1ffff, 1));
      rt = 4'($urandom);
      rd = int'($urandom_range(5, 0));
      rr = int'($urandom_range(12, 0));
      rq = int'($urandom_range(5, 0));
      re = ($urandom_range(2, 0) == 0);
      model(ra, rd, rr, rq, re, est, ert, edn);
      push(ra, rt);
      serve(ra, rt, rd, rr, rq, re, est, ert, edn, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
